fp_normalizer: RTL and testbench

Multi-cycle normalizer for the two's-complement to floating-point converter. Accepts a 12-bit two's-complement sample, forms sign and clamped magnitude, then left-shifts one bit per cycle until the leading one reaches the top of the significand window. It produces the sign, the unrounded exponent, the 5-bit significand and the sixth (round) bit that feed the downstream rounder directly. Valid/ready handshakes sit on both sides, so the converter can pace inputs against a slow consumer.

---
 rtl/fp_normalizer.sv | 124 ++++++++++++
 tb/tb_fp_normalizer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Two's-complement (12-bit) to unrounded sign/exponent/significand normalizer.
// Optional single-cycle shift via FP_NORMALIZER_FAST_EN; default is one bit per cycle.
`timescale 1ns/1ps

module fp_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] d_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [2:0]  e_out,
  output logic [4:0]  f_out,
  output logic        sixth,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ABS   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its data stable while valid is high and ready is low, and
  // valid never drops without a transfer (other than by reset).

  logic [1:0]  state;
  logic [11:0] work;
  logic [10:0] mag;
  logic [10:0] abs_mag;

  // -2048 has no positive 12-bit counterpart, so it saturates to 2047.
  always_comb begin
    abs_mag = work[10:0];
    if (work == 12'h800)
      abs_mag = 11'h7FF;
    else if (work[11])
      abs_mag = ~work[10:0] + 11'd1;
  end

  assign in_ready  = (state == S_IDLE);
  assign dbg_state = state;

`ifdef FP_NORMALIZER_FAST_EN
  logic [2:0] lead_k;
  logic [5:0] shifted_top;

  // Shift distance that brings the leading one to bit 10, capped at 6.
  always_comb begin
    lead_k = 3'd6;
    for (int i = 4; i <= 10; i++) begin
      if (mag[i])
        lead_k = 3'(10 - i);
    end
    shifted_top = 6'((mag << lead_k) >> 5);
  end
`else
  logic [2:0] exp_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      work      <= '0;
      mag       <= '0;
      sign      <= 1'b0;
      e_out     <= '0;
      f_out     <= '0;
      sixth     <= 1'b0;
      out_valid <= 1'b0;
`ifndef FP_NORMALIZER_FAST_EN
      exp_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work  <= d_in;
            state <= S_ABS;
          end
        end
        S_ABS: begin
          sign  <= work[11];
          mag   <= abs_mag;
`ifndef FP_NORMALIZER_FAST_EN
          exp_cnt <= 3'd6;
`endif
          state <= S_SHIFT;
        end
        S_SHIFT: begin
`ifdef FP_NORMALIZER_FAST_EN
          e_out     <= 3'd6 - lead_k;
          f_out     <= shifted_top[5:1];
          sixth     <= shifted_top[0];
          out_valid <= 1'b1;
          state     <= S_DONE;
`else
          // Stop once normalized, or once the exponent floor is reached.
          if (mag[10] || exp_cnt == 3'd0) begin
            e_out     <= exp_cnt;
            f_out     <= mag[10:6];
            sixth     <= mag[5];
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            mag     <= {mag[9:0], 1'b0};
            exp_cnt <= exp_cnt - 3'd1;
          end
`endif
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed cases, backpressure,
// mid-operation reset and randomized back-to-back traffic.
`timescale 1ns/1ps

module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] d_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign;
  logic [2:0]  e_out;
  logic [4:0]  f_out;
  logic        sixth;
  logic [1:0]  dbg_state;

  logic [9:0] exp_q[$];
  int         exp_lat_q[$];
  int         errors = 0;
  int         checks = 0;

  fp_normalizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .e_out(e_out), .f_out(f_out), .sixth(sixth),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference mapping from the leading-one position of the magnitude.
  function automatic logic [9:0] model(input logic [11:0] d);
    int v, m, p;
    logic s, sx;
    logic [2:0] e;
    logic [4:0] f;
    v = int'($signed(d));
    s = d[11];
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    p = -1;
    for (int i = 0; i < 12; i++) if (m[i]) p = i;
    if (m < 16) begin
      e = 3'd0; f = m[4:0]; sx = 1'b0;
    end else begin
      e = 3'(p - 4);
      f = 5'(m >> (p - 4));
      sx = 1'b0;
      if (p >= 5) sx = m[p-5];
    end
    return {s, e, f, sx};
  endfunction

  // Cycles from capture edge N to the edge where out_valid is first seen high.
  function automatic int model_lat(input logic [11:0] d);
    int v, m, p;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    p = -1;
    for (int i = 0; i < 12; i++) if (m[i]) p = i;
`ifdef FP_NORMALIZER_FAST_EN
    return 3;
`else
    return (m < 16) ? 9 : 3 + (10 - p);
`endif
  endfunction

  task automatic send(input logic [11:0] d, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    d_in = d;
    if (push) begin
      exp_q.push_back(model(d));
      exp_lat_q.push_back(model_lat(d));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    d_in = 12'($urandom);
  endtask

  // Wait for a result, compare against the scoreboard, optionally hand it off.
  task automatic collect(input string name, input bit handoff);
    int j;
    logic [9:0] exp_v;
    int exp_l;
    j = 0;
    while (!out_valid && j < 20) begin
      @(posedge clk); #1; j++;
    end
    exp_v = exp_q.pop_front();
    exp_l = exp_lat_q.pop_front();
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", name, j);
      return;
    end
    // out_valid is set by edge N+j, so the consumer first sees it at edge N+j+1.
    checks++;
    if (j + 1 != exp_l) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, j + 1, exp_l);
    end
    checks++;
    if ({sign, e_out, f_out, sixth} !== exp_v) begin
      errors++;
      $display("FAIL %s_result: sign=%0b e=%0d f=%b sixth=%0b required sign=%0b e=%0d f=%b sixth=%0b",
               name, sign, e_out, f_out, sixth, exp_v[9], exp_v[8:6], exp_v[5:1], exp_v[0]);
    end
    if (handoff) handoff_check(name);
  endtask

  task automatic handoff_check(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handoff: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({out_valid, sign, e_out, f_out, sixth} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {out_valid, sign, e_out, f_out, sixth});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    send(12'h7FF, 1'b1); collect("max_pos", 1'b1);
    send(12'h800, 1'b1); collect("clamp", 1'b1);
    send(12'h1A6, 1'b1); collect("mid_422", 1'b1);
    send(12'hFD6, 1'b1); collect("neg_42", 1'b1);
    send(12'h000, 1'b1); collect("zero", 1'b1);
    send(12'h00F, 1'b1); collect("below16", 1'b1);
    send(12'h010, 1'b1); collect("exact16", 1'b1);
    send(12'hC00, 1'b1); collect("neg_1024", 1'b1);
  endtask

  task automatic test_backpressure();
    logic [9:0] held;
    send(12'h1A6, 1'b1);
    collect("bp_first", 1'b0);
    held = {sign, e_out, f_out, sixth};
    for (int c = 0; c < 4; c++) begin
      in_valid = ~in_valid;
      d_in = 12'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sign, e_out, f_out, sixth} !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%0b in_ready=%0b result=%b required 1/0/%b",
                 c, out_valid, in_ready, {sign, e_out, f_out, sixth}, held);
      end
    end
    in_valid = 1'b0;
    handoff_check("bp");
  endtask

  task automatic test_reset_mid();
    int seen;
    send(12'hFFB, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL rmid_in_shift: state=%0d required 2", dbg_state);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({out_valid, sign, e_out, f_out, sixth} !== 11'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_clear: outputs=%b in_ready=%0b required 0/1",
               {out_valid, sign, e_out, f_out, sixth}, in_ready);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmid_no_emit: out_valid high %0d cycles required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      send(12'($urandom_range(0, 4095)), 1'b1);
      collect("rand", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
